// File: rtl/decoder_pkg.sv
// Shared widths and helpers for the registered line-decoder family.
package decoder_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OUT_W = 16;

  // Returns the all-idle output vector for the chosen polarity.
  function automatic logic [OUT_W-1:0] onehot_idle(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Combinational active-high 2-to-4 decoder leaf; reusable outside the 4x16 tree.
module decoder_2x4 (
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] Q
);

  always_comb begin
    Q = '0;
    if (E) Q = 4'b0001 << A;
  end

endmodule

// File: rtl/decoder_4x16.sv
// Registered 4-to-16 one-hot decoder with enable, built from a tree of 2-to-4 leaves.
module decoder_4x16 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [decoder_pkg::SEL_W-1:0] X,
  input  logic                          En,
  output logic [decoder_pkg::OUT_W-1:0] Y,
  output logic                          Any
);
  import decoder_pkg::*;

  logic [3:0]       grp_en;
  logic [OUT_W-1:0] dec_hot;
  logic [OUT_W-1:0] y_d, y_q;
  logic             any_d, any_q;

  decoder_2x4 u_hi (
    .A (X[3:2]),
    .E (En),
    .Q (grp_en)
  );

  for (genvar k = 0; k < 4; k++) begin : g_lo
    decoder_2x4 u_lo (
      .A (X[1:0]),
      .E (grp_en[k]),
      .Q (dec_hot[4*k+3:4*k])
    );
  end

  // The tree is all-zero when En is low, so inverting it also yields IDLE.
  always_comb begin
    y_d   = ACTIVE_LOW ? ~dec_hot : dec_hot;
    any_d = En;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= onehot_idle(ACTIVE_LOW);
      any_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      any_q <= any_d;
    end
  end

  assign Y   = y_q;
  assign Any = any_q;

endmodule

// File: tb/tb_decoder_4x16.sv
// Scoreboard bench for decoder_4x16 (both polarities) and the decoder_2x4 leaf.
module tb_decoder_4x16;

  typedef struct {
    string       name;
    logic [15:0] y;
    logic        any;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  x   = '0;
  logic        en  = 1'b0;
  logic [15:0] y_hi, y_lo;
  logic        any_hi, any_lo;

  logic [1:0]  leaf_a = '0;
  logic        leaf_e = 1'b0;
  logic [3:0]  leaf_q;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  decoder_4x16 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk), .rst (rst), .X (x), .En (en), .Y (y_hi), .Any (any_hi)
  );

  decoder_4x16 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk), .rst (rst), .X (x), .En (en), .Y (y_lo), .Any (any_lo)
  );

  decoder_2x4 dut_leaf (.A (leaf_a), .E (leaf_e), .Q (leaf_q));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation is retired per clock, checked 1ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, " Y"},        y_hi,                    e.y);
      check({e.name, " Any"},      {15'd0, any_hi},         {15'd0, e.any});
      check({e.name, " onehot"},   16'($countones(y_hi)),   {15'd0, e.any});
      check({e.name, " Y_al"},     y_lo,                    ~e.y);
      check({e.name, " Any_al"},   {15'd0, any_lo},         {15'd0, e.any});
    end
  end

  // Drive one cycle of inputs on the falling edge and queue the hand-computed result.
  task automatic drive(input string name, input logic r, input logic [3:0] xv,
                       input logic ev, input logic [15:0] ey, input logic ea);
    exp_t e;
    @(negedge clk);
    rst = r; x = xv; en = ev;
    e.name = name; e.y = ey; e.any = ea;
    sb.push_back(e);
  endtask

  logic [3:0]  gate_x [4] = '{4'h0, 4'h1, 4'h6, 4'hC};
  logic [15:0] gate_y [4] = '{16'h0001, 16'h0002, 16'h0040, 16'h1000};
  logic [3:0]  leaf_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    // Leaf decoder, purely combinational.
    for (int i = 0; i < 4; i++) begin
      leaf_e = 1'b1; leaf_a = 2'(i); #1;
      check("leaf_en", {12'd0, leaf_q}, {12'd0, leaf_y[i]});
      leaf_e = 1'b0; #1;
      check("leaf_dis", {12'd0, leaf_q}, 16'h0000);
    end

    for (int i = 0; i < 3; i++) drive("reset", 1'b1, 4'h5, 1'b1, 16'h0000, 1'b0);
    drive("rst_release", 1'b0, 4'h5, 1'b1, 16'h0020, 1'b1);

    for (int i = 0; i < 16; i++) drive("sweep", 1'b0, 4'(i), 1'b1, 16'h0001 << i, 1'b1);

    for (int i = 0; i < 4; i++) drive("gate_off", 1'b0, gate_x[i], 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) drive("gate_on",  1'b0, gate_x[i], 1'b1, gate_y[i], 1'b1);

    drive("b2b_3",   1'b0, 4'h3, 1'b1, 16'h0008, 1'b1);
    drive("b2b_c",   1'b0, 4'hC, 1'b1, 16'h1000, 1'b1);
    drive("mid_rst", 1'b1, 4'hC, 1'b1, 16'h0000, 1'b0);

    drive("al_a",    1'b0, 4'hA, 1'b1, 16'h0400, 1'b1);
    drive("al_off",  1'b0, 4'hA, 1'b0, 16'h0000, 1'b0);
    drive("en_fall", 1'b0, 4'h7, 1'b1, 16'h0080, 1'b1);
    drive("en_low",  1'b0, 4'h7, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
